mdu_issue_queue: RTL and testbench



---
 rtl/uarch_pkg.sv | 34 +++
 rtl/oldest_ready_select.sv | 28 ++
 rtl/mdu_issue_queue.sv | 109 ++++++++++
 tb/tb_mdu_issue_queue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uarch_pkg.sv
// Shared micro-architecture types: operand, instruction and writeback packets,
// plus the MDU issue queue depth.
package uarch_pkg;

  localparam int XLEN           = 32;
  localparam int TAG_W          = 6;
  localparam int MDU_IQ_ENTRIES = 4;

  typedef enum logic [2:0] {
    MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
    MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
  } mdu_op_t;

  typedef struct packed {
    logic              is_renamed;
    logic [TAG_W-1:0]  tag;
    logic [XLEN-1:0]   data;
  } source_operand_t;

  typedef struct packed {
    logic             is_valid;
    mdu_op_t          op;
    logic [TAG_W-1:0] dest_tag;
    source_operand_t  src_0_a;
    source_operand_t  src_0_b;
  } instruction_t;

  typedef struct packed {
    logic             is_valid;
    logic [TAG_W-1:0] dest_tag;
    logic [XLEN-1:0]  result;
  } writeback_packet_t;

endpackage

// File: rtl/oldest_ready_select.sv
// Priority encoder: grants the lowest-index requester (the oldest entry in an
// age-ordered queue) as one-hot plus binary index.
module oldest_ready_select #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Scan from the top so the lowest set bit is the one left standing.
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mdu_issue_queue.sv
// Collapsing, age-ordered reservation station in front of the MDU: captures
// operands from the CDB and offers the oldest ready entry on mdu_packet.
module mdu_issue_queue
  import uarch_pkg::*;
#(
  parameter int NUM_ENTRIES = MDU_IQ_ENTRIES,
  parameter int NUM_CDB     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  instruction_t      dispatch_packet,
  output logic              dispatch_rdy,
  output instruction_t      mdu_packet,
  input  logic              mdu_rdy,
  input  writeback_packet_t cdb [NUM_CDB]
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

  instruction_t             q      [NUM_ENTRIES];
  instruction_t             nxt_q  [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]   vld, nxt_vld, ready, grant;
  logic [CNT_W-1:0]         count, nxt_count, wr_idx;
  logic [IDX_W-1:0]         sel_idx;
  logic                     sel_any, issue, accept;

  always_comb begin
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      ready[k] = vld[k] && !q[k].src_0_a.is_renamed && !q[k].src_0_b.is_renamed;
    end
  end

  oldest_ready_select #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_select (
    .req   (ready),
    .grant (grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  always_comb begin
    mdu_packet = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (grant[k]) mdu_packet = q[k];
    end
    if (sel_any) mdu_packet.is_valid = 1'b1;
  end

  assign dispatch_rdy = (count < CNT_W'(NUM_ENTRIES));
  assign issue        = sel_any && mdu_rdy;
  assign accept       = dispatch_packet.is_valid && dispatch_rdy;
  // Dispatch lands just past the last valid entry after any collapse.
  assign wr_idx       = issue ? count - CNT_W'(1) : count;
  assign nxt_count    = count + CNT_W'(accept) - CNT_W'(issue);

  always_comb begin
    nxt_q   = q;
    nxt_vld = vld;
    if (issue) begin
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        if (k >= int'(sel_idx)) begin
          nxt_q[k]   = q[(k < NUM_ENTRIES - 1) ? k + 1 : k];
          nxt_vld[k] = (k < NUM_ENTRIES - 1) ? vld[(k < NUM_ENTRIES - 1) ? k + 1 : k] : 1'b0;
        end
      end
    end
    if (accept) begin
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        if (CNT_W'(k) == wr_idx) begin
          nxt_q[k]   = dispatch_packet;
          nxt_vld[k] = 1'b1;
        end
      end
    end
    // Wakeup after collapse/insert so shifted and newly dispatched entries
    // never miss a broadcast; the first matching port clears is_renamed,
    // so the lowest-index port wins.
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      for (int i = 0; i < NUM_CDB; i++) begin
        if (cdb[i].is_valid) begin
          if (nxt_q[k].src_0_a.is_renamed && nxt_q[k].src_0_a.tag == cdb[i].dest_tag) begin
            nxt_q[k].src_0_a.data       = cdb[i].result;
            nxt_q[k].src_0_a.is_renamed = 1'b0;
          end
          if (nxt_q[k].src_0_b.is_renamed && nxt_q[k].src_0_b.tag == cdb[i].dest_tag) begin
            nxt_q[k].src_0_b.data       = cdb[i].result;
            nxt_q[k].src_0_b.is_renamed = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld   <= '0;
      count <= '0;
    end else begin
      vld   <= nxt_vld;
      count <= nxt_count;
    end
  end

  always_ff @(posedge clk) begin
    q <= nxt_q;
  end

endmodule

// File: tb/tb_mdu_issue_queue.sv
// Randomised and directed bench for mdu_issue_queue against an age-ordered
// queue model of the reservation station.
module tb_mdu_issue_queue;
  import uarch_pkg::*;

  localparam int N  = MDU_IQ_ENTRIES;
  localparam int NC = 2;

  logic              clk = 1'b0;
  logic              rst, flush, dispatch_rdy, mdu_rdy;
  instruction_t      dispatch_packet, mdu_packet;
  writeback_packet_t cdb [NC];

  int n_tests = 0;
  int n_fail  = 0;
  instruction_t model [$];

  always #5 clk = ~clk;

  mdu_issue_queue #(.NUM_ENTRIES(N), .NUM_CDB(NC)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .dispatch_packet (dispatch_packet),
    .dispatch_rdy    (dispatch_rdy),
    .mdu_packet      (mdu_packet),
    .mdu_rdy         (mdu_rdy),
    .cdb             (cdb)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic source_operand_t mk_op(bit waiting, int tag, logic [XLEN-1:0] data);
    source_operand_t o;
    o.is_renamed = waiting;
    o.tag        = TAG_W'(tag);
    o.data       = data;
    return o;
  endfunction

  function automatic instruction_t mk_ins(mdu_op_t op, int dest, source_operand_t a, source_operand_t b);
    instruction_t i;
    i.is_valid = 1'b1;
    i.op       = op;
    i.dest_tag = TAG_W'(dest);
    i.src_0_a  = a;
    i.src_0_b  = b;
    return i;
  endfunction

  function automatic source_operand_t m_wake(source_operand_t o);
    for (int i = 0; i < NC; i++) begin
      if (o.is_renamed && cdb[i].is_valid && cdb[i].dest_tag == o.tag) begin
        o.data       = cdb[i].result;
        o.is_renamed = 1'b0;
      end
    end
    return o;
  endfunction

  function automatic int m_sel();
    for (int k = 0; k < model.size(); k++) begin
      if (!model[k].src_0_a.is_renamed && !model[k].src_0_b.is_renamed) return k;
    end
    return -1;
  endfunction

  task automatic idle();
    dispatch_packet = '0;
    mdu_rdy         = 1'b0;
    flush           = 1'b0;
    rst             = 1'b0;
    for (int i = 0; i < NC; i++) cdb[i] = '0;
  endtask

  // Called at a falling edge with inputs already driven: checks outputs,
  // advances the model by one clock, and returns at the next falling edge.
  task automatic cycle();
    int           s;
    instruction_t exp, t;
    s   = m_sel();
    exp = '0;
    if (s >= 0) begin
      exp          = model[s];
      exp.is_valid = 1'b1;
    end
    chk("mdu_packet", mdu_packet, exp);
    chk("dispatch_rdy", dispatch_rdy, model.size() < N);
    if (rst || flush) begin
      model.delete();
    end else begin
      bit acc;
      acc = dispatch_packet.is_valid && (model.size() < N);
      if (s >= 0 && mdu_rdy) model.delete(s);
      if (acc) model.push_back(dispatch_packet);
      for (int k = 0; k < model.size(); k++) begin
        t         = model[k];
        t.src_0_a = m_wake(t.src_0_a);
        t.src_0_b = m_wake(t.src_0_b);
        model[k]  = t;
      end
    end
    @(negedge clk);
  endtask

  function automatic instruction_t rnd_ins();
    return mk_ins(mdu_op_t'($urandom_range(0, 7)), $urandom_range(0, 63),
                  mk_op($urandom_range(0, 9) < 4, $urandom_range(0, 7), $urandom),
                  mk_op($urandom_range(0, 9) < 4, $urandom_range(0, 7), $urandom));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dispatch_rdy", dispatch_rdy, 1'b1);
    chk("rst_mdu_packet", mdu_packet, '0);
    idle();

    // MUL with both operands ready issues one cycle after dispatch.
    mdu_rdy = 1'b1;
    dispatch_packet = mk_ins(MDU_MUL, 1, mk_op(0, 0, 7), mk_op(0, 0, 6));
    cycle();
    idle(); mdu_rdy = 1'b1;
    chk("mul_vld", mdu_packet.is_valid, 1'b1);
    chk("mul_a", mdu_packet.src_0_a.data, 7);
    chk("mul_b", mdu_packet.src_0_b.data, 6);
    cycle();
    idle();
    chk("mul_gone", mdu_packet, '0);

    // DIV waiting on tag 5; broadcast two cycles after dispatch.
    dispatch_packet = mk_ins(MDU_DIV, 2, mk_op(0, 0, 100), mk_op(1, 5, 0));
    cycle();
    idle();
    cycle();
    idle();
    chk("div_wait", mdu_packet.is_valid, 1'b0);
    cdb[0] = '{is_valid: 1'b1, dest_tag: TAG_W'(5), result: 32'd3};
    cycle();
    idle(); mdu_rdy = 1'b1;
    chk("div_vld", mdu_packet.is_valid, 1'b1);
    chk("div_b_data", mdu_packet.src_0_b.data, 3);
    chk("div_b_ren", mdu_packet.src_0_b.is_renamed, 1'b0);
    cycle();

    // Fill the queue, drop a fifth dispatch, then drain in age order.
    for (int k = 0; k < N; k++) begin
      idle();
      dispatch_packet = mk_ins(MDU_MUL, 20 + k, mk_op(0, 0, k), mk_op(0, 0, k));
      cycle();
    end
    idle();
    chk("full_rdy", dispatch_rdy, 1'b0);
    dispatch_packet = mk_ins(MDU_MUL, 40, mk_op(0, 0, 0), mk_op(0, 0, 0));
    cycle();
    for (int k = 0; k < N; k++) begin
      idle(); mdu_rdy = 1'b1;
      chk("drain_order", mdu_packet.dest_tag, 20 + k);
      cycle();
    end
    idle();
    chk("drain_rdy", dispatch_rdy, 1'b1);
    chk("drain_empty", mdu_packet, '0);

    // Younger ready entry bypasses an older waiting one.
    dispatch_packet = mk_ins(MDU_REM, 10, mk_op(1, 3, 0), mk_op(0, 0, 1));
    cycle();
    idle();
    dispatch_packet = mk_ins(MDU_REM, 11, mk_op(0, 0, 2), mk_op(0, 0, 2));
    cycle();
    idle(); mdu_rdy = 1'b1;
    chk("bypass_first", mdu_packet.dest_tag, 11);
    cycle();
    idle();
    chk("bypass_wait", mdu_packet.is_valid, 1'b0);
    cdb[1] = '{is_valid: 1'b1, dest_tag: TAG_W'(3), result: 32'h55};
    cycle();
    idle(); mdu_rdy = 1'b1;
    chk("bypass_second", mdu_packet.dest_tag, 10);
    chk("bypass_data", mdu_packet.src_0_a.data, 32'h55);
    cycle();

    // Same-cycle capture at dispatch; port 0 wins over port 1.
    idle();
    dispatch_packet = mk_ins(MDU_MULH, 12, mk_op(1, 9, 0), mk_op(0, 0, 4));
    cdb[0] = '{is_valid: 1'b1, dest_tag: TAG_W'(9), result: 32'hDEAD};
    cdb[1] = '{is_valid: 1'b1, dest_tag: TAG_W'(9), result: 32'hBEEF};
    cycle();
    idle(); mdu_rdy = 1'b1;
    chk("capture_vld", mdu_packet.is_valid, 1'b1);
    chk("capture_data", mdu_packet.src_0_a.data, 32'hDEAD);
    cycle();

    // Flush with three entries and a concurrent dispatch.
    for (int k = 0; k < 3; k++) begin
      idle();
      dispatch_packet = mk_ins(MDU_DIVU, 30 + k, mk_op(0, 0, k), mk_op(1, 7, 0));
      cycle();
    end
    idle();
    flush = 1'b1;
    dispatch_packet = mk_ins(MDU_MUL, 33, mk_op(0, 0, 1), mk_op(0, 0, 1));
    cycle();
    idle();
    chk("flush_pkt", mdu_packet, '0);
    chk("flush_rdy", dispatch_rdy, 1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      idle();
      if ($urandom_range(0, 9) < 6) dispatch_packet = rnd_ins();
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 9) < 3)
          cdb[i] = '{is_valid: 1'b1, dest_tag: TAG_W'($urandom_range(0, 7)), result: $urandom};
      end
      mdu_rdy = ($urandom_range(0, 9) < 6);
      flush   = ($urandom_range(0, 99) < 2);
      rst     = ($urandom_range(0, 99) < 1);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
